// File: rtl/ps2_key_event_controller.sv
// rtl/ps2_key_event_controller.sv - PS2 scancode decoder: F0/E0 prefixes, key levels, key events.
// Optional post-release hold-off window is built when PS2_KEY_HOLDOFF_EN is defined.
module ps2_key_event_controller #(
    parameter int unsigned HOLDOFF_CYCLES = 5000000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    output logic       wait_for_incoming_data,
    output logic       space_pressed,
    output logic       enter_pressed,
    output logic       one_pressed,
    output logic       two_pressed,
    output logic       key_event,
    output logic [1:0] key_id,
    output logic       key_make
);

    localparam int unsigned CNT_MAX = (HOLDOFF_CYCLES > TIMEOUT_CYCLES) ? HOLDOFF_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CW      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(TIMEOUT_CYCLES - 1);

`ifdef PS2_KEY_HOLDOFF_EN
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLDOFF_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, GOT_E0, GOT_F0, GOT_E0F0, HOLDOFF
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, GOT_E0, GOT_F0, GOT_E0F0
    } state_t;
`endif

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          data_en_q;
    logic [3:0]    keys_q;
    logic          key_event_q;
    logic [1:0]    key_id_q;
    logic          key_make_q;
`ifdef PS2_KEY_HOLDOFF_EN
    logic          wait_q;
`endif

    logic       accept;
    logic       is_e0;
    logic       is_f0;
    logic       map_hit;
    logic [1:0] map_id;

    // After E0 F0 only keypad enter is recognised; bare codes map all four keys.
    function automatic logic [2:0] map_code(input logic [7:0] code, input logic ext);
        case (code)
            8'h29:   map_code = {~ext, 2'd0};
            8'h5A:   map_code = {1'b1, 2'd1};
            8'h16:   map_code = {~ext, 2'd2};
            8'h1E:   map_code = {~ext, 2'd3};
            default: map_code = 3'b000;
        endcase
    endfunction

    always_comb begin
        accept = received_data_en & ~data_en_q;
`ifdef PS2_KEY_HOLDOFF_EN
        if (state_q == HOLDOFF) begin
            accept = 1'b0;
        end
`endif
        is_e0 = (received_data == 8'hE0);
        is_f0 = (received_data == 8'hF0);
        {map_hit, map_id} = map_code(received_data, state_q == GOT_E0F0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            data_en_q   <= 1'b0;
            keys_q      <= '0;
            key_event_q <= 1'b0;
            key_id_q    <= 2'd0;
            key_make_q  <= 1'b0;
`ifdef PS2_KEY_HOLDOFF_EN
            wait_q      <= 1'b1;
`endif
        end else begin
            data_en_q   <= received_data_en;
            key_event_q <= 1'b0;
            if (accept) begin
                case (state_q)
                    IDLE: begin
                        if (is_e0) begin
                            state_q <= GOT_E0;
                            cnt_q   <= TIMEOUT_LOAD;
                        end else if (is_f0) begin
                            state_q <= GOT_F0;
                            cnt_q   <= TIMEOUT_LOAD;
                        end else if (map_hit && !keys_q[map_id]) begin
                            keys_q[map_id] <= 1'b1;
                            key_event_q    <= 1'b1;
                            key_id_q       <= map_id;
                            key_make_q     <= 1'b1;
                        end
                    end
                    GOT_E0: begin
                        if (is_f0) begin
                            state_q <= GOT_E0F0;
                            cnt_q   <= TIMEOUT_LOAD;
                        end else if (is_e0) begin
                            cnt_q   <= TIMEOUT_LOAD;
                        end else begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            if (received_data == 8'h5A && !keys_q[1]) begin
                                keys_q[1]   <= 1'b1;
                                key_event_q <= 1'b1;
                                key_id_q    <= 2'd1;
                                key_make_q  <= 1'b1;
                            end
                        end
                    end
                    GOT_F0, GOT_E0F0: begin
                        if (is_f0) begin
                            state_q <= GOT_F0;
                            cnt_q   <= TIMEOUT_LOAD;
                        end else if (is_e0) begin
                            state_q <= GOT_E0;
                            cnt_q   <= TIMEOUT_LOAD;
                        end else begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            if (map_hit) begin
                                keys_q[map_id] <= 1'b0;
                                // Only a genuine release (level was 1) produces an event.
                                if (keys_q[map_id]) begin
                                    key_event_q <= 1'b1;
                                    key_id_q    <= map_id;
                                    key_make_q  <= 1'b0;
`ifdef PS2_KEY_HOLDOFF_EN
                                    state_q     <= HOLDOFF;
                                    cnt_q       <= HOLD_LOAD;
                                    wait_q      <= 1'b0;
`endif
                                end
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end else begin
                case (state_q)
                    GOT_E0, GOT_F0, GOT_E0F0: begin
                        if (cnt_q == '0) begin
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
`ifdef PS2_KEY_HOLDOFF_EN
                    HOLDOFF: begin
                        if (cnt_q == '0) begin
                            state_q <= IDLE;
                            wait_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

`ifdef PS2_KEY_HOLDOFF_EN
    assign wait_for_incoming_data = wait_q;
`else
    assign wait_for_incoming_data = 1'b1;
`endif
    assign space_pressed = keys_q[0];
    assign enter_pressed = keys_q[1];
    assign one_pressed   = keys_q[2];
    assign two_pressed   = keys_q[3];
    assign key_event     = key_event_q;
    assign key_id        = key_id_q;
    assign key_make      = key_make_q;

endmodule

// File: tb/tb_ps2_key_event_controller.sv
// tb/tb_ps2_key_event_controller.sv - scoreboard bench for ps2_key_event_controller.
module tb_ps2_key_event_controller;

`ifdef PS2_KEY_HOLDOFF_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] received_data = 8'h00;
    logic       received_data_en = 1'b0;
    logic       wait_for_incoming_data;
    logic       space_pressed, enter_pressed, one_pressed, two_pressed;
    logic       key_event;
    logic [1:0] key_id;
    logic       key_make;

    int n_cmp = 0;
    int n_err = 0;
    logic [2:0] exp_q[$];

    ps2_key_event_controller #(
        .HOLDOFF_CYCLES(8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .received_data         (received_data),
        .received_data_en      (received_data_en),
        .wait_for_incoming_data(wait_for_incoming_data),
        .space_pressed         (space_pressed),
        .enter_pressed         (enter_pressed),
        .one_pressed           (one_pressed),
        .two_pressed           (two_pressed),
        .key_event             (key_event),
        .key_id                (key_id),
        .key_make              (key_make)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0b required=%0b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic expect_ev(input logic [1:0] id, input logic make);
        exp_q.push_back({id, make});
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        received_data    = b;
        received_data_en = 1'b1;
        repeat (2) @(negedge clk);
        received_data_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_rx_enable();
        for (int i = 0; i < 50 && !wait_for_incoming_data; i++) @(negedge clk);
        chk1("holdoff_exit", wait_for_incoming_data, 1'b1);
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        chk1({tag, "_wait"},  wait_for_incoming_data, 1'b1);
        chk1({tag, "_space"}, space_pressed, 1'b0);
        chk1({tag, "_enter"}, enter_pressed, 1'b0);
        chk1({tag, "_one"},   one_pressed, 1'b0);
        chk1({tag, "_two"},   two_pressed, 1'b0);
        chk1({tag, "_event"}, key_event, 1'b0);
        chk32({tag, "_id"},   int'(key_id), 0);
        chk1({tag, "_make"},  key_make, 1'b0);
    endtask

    // Monitor: every key_event cycle must match the oldest expected event.
    always @(negedge clk) begin
        if (!reset && key_event) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event actual id=%0d make=%0b required none", key_id, key_make);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                if ({key_id, key_make} !== e) begin
                    n_err++;
                    $display("FAIL event actual id=%0d make=%0b required id=%0d make=%0b",
                             key_id, key_make, e[2:1], e[0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1);
    end

    initial begin
        int low_cnt;
        #3;
        check_reset_vals("reset");
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Space make, then F0 29 break with enable low for the hold-off window
        expect_ev(2'd0, 1'b1);
        send(8'h29);
        chk1("space_after_make", space_pressed, 1'b1);
        send(8'hF0);
        expect_ev(2'd0, 1'b0);
        @(negedge clk);
        received_data    = 8'h29;
        received_data_en = 1'b1;
        @(negedge clk);
        received_data_en = 1'b0;
        chk1("space_after_break", space_pressed, 1'b0);
        low_cnt = 0;
        while (!wait_for_incoming_data && low_cnt < 100) begin
            low_cnt++;
            @(negedge clk);
        end
        chk32("wait_low_clks", low_cnt, HOLD_EN ? 8 : 0);
        wait_rx_enable();

        // Typematic repeat of key one
        expect_ev(2'd2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            send(8'h16);
            chk1("one_level_repeat", one_pressed, 1'b1);
        end

        // Extended enter make and break, then an unmapped code
        send(8'hE0);
        expect_ev(2'd1, 1'b1);
        send(8'h5A);
        chk1("enter_make", enter_pressed, 1'b1);
        send(8'hE0);
        send(8'hF0);
        expect_ev(2'd1, 1'b0);
        send(8'h5A);
        chk1("enter_break", enter_pressed, 1'b0);
        wait_rx_enable();
        send(8'h1C);
        chk1("unmapped_no_level", two_pressed, 1'b0);

        // Release one, then send 1E while the hold-off window is open
        send(8'hF0);
        expect_ev(2'd2, 1'b0);
        send(8'h16);
        chk1("one_released", one_pressed, 1'b0);
        if (!HOLD_EN) expect_ev(2'd3, 1'b1);
        send(8'h1E);
        chk1("two_during_holdoff", two_pressed, !HOLD_EN);
        wait_rx_enable();
        if (HOLD_EN) expect_ev(2'd3, 1'b1);
        send(8'h1E);
        chk1("two_after_holdoff", two_pressed, 1'b1);

        // Prefix timeout: F0 then a long gap makes the following 29 a press
        send(8'hF0);
        repeat (20) @(negedge clk);
        expect_ev(2'd0, 1'b1);
        send(8'h29);
        chk1("space_make_after_timeout", space_pressed, 1'b1);
        send(8'hF0);
        repeat (5) @(negedge clk);
        expect_ev(2'd0, 1'b0);
        send(8'h29);
        chk1("space_break_within_timeout", space_pressed, 1'b0);
        wait_rx_enable();

        // Async reset in the middle of hold-off
        send(8'hF0);
        expect_ev(2'd3, 1'b0);
        @(negedge clk);
        received_data    = 8'h1E;
        received_data_en = 1'b1;
        @(negedge clk);
        received_data_en = 1'b0;
        @(negedge clk);
        chk1("wait_in_holdoff", wait_for_incoming_data, !HOLD_EN);
        #2 reset = 1'b1;
        #1 check_reset_vals("rst_holdoff");
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // Async reset while in GOT_F0: the next 29 is a press
        expect_ev(2'd0, 1'b1);
        send(8'h29);
        send(8'hF0);
        #2 reset = 1'b1;
        #1 check_reset_vals("rst_prefix");
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        expect_ev(2'd0, 1'b1);
        send(8'h29);
        chk1("space_after_reset", space_pressed, 1'b1);

        repeat (3) @(negedge clk);
        chk32("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
